// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the 5-stage RISC-V core.
// Fetch-stage additions: NOP encoding, fetch FSM states, IF/ID record.
package core_pkg;

    // addi x0, x0, 0 -- the canonical bubble instruction
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Priority: flush (bubble) > stall (hold) > load delivered instruction > bubble.
module if_id_reg
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t load,
    output if_id_t q
);

    // IF/ID update with flush/stall/load priority
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            q <= '{instr: INSTR_NOP, pc: 32'h0, valid: 1'b0};
        end else if (flush) begin
            q <= '{instr: INSTR_NOP, pc: q.pc, valid: 1'b0};
        end else if (stall) begin
            q <= q;
        end else if (load.valid) begin
            q <= load;
        end else begin
            q <= '{instr: INSTR_NOP, pc: q.pc, valid: 1'b0};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC, single-outstanding req/gnt/rvalid instruction fetch,
// one-entry hold buffer for responses that arrive under stall, and the IF/ID
// register. Optional macro FETCH_PERF_CNT_EN adds stall/flush counters.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_ip,
    input  logic        branch_taken_ip,
    input  logic [31:0] branch_target_ip,
    output logic        instr_req_op,
    output logic [31:0] instr_addr_op,
    input  logic        instr_gnt_ip,
    input  logic        instr_rvalid_ip,
    input  logic [31:0] instr_rdata_ip,
    output logic [31:0] ID_instr_op,
    output logic [31:0] ID_pc_op,
    output logic        ID_valid_op
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_op,
    output logic [31:0] flush_cnt_op
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  hold_instr_q, hold_pc_q;
    logic         hold_load;
    logic [31:0]  target;
    if_id_t       deliver;
    if_id_t       if_id_q;
    logic         unused_target_lsbs;

    assign target             = {branch_target_ip[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_target_ip[1:0];

    // While a redirected request is still waiting for gnt, keep the stale
    // address on the bus so req/addr stay stable until the handshake completes.
    assign instr_req_op  = (state_q == FETCH_REQ);
    assign instr_addr_op = drop_q ? inflight_pc_q : fetch_pc_q;

    // Next-state, PC, drop flag and delivery decode
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves a latch.
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        hold_load     = 1'b0;
        deliver       = '{instr: INSTR_NOP, pc: 32'h0, valid: 1'b0};

        unique case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
                if (branch_taken_ip) fetch_pc_d = target;
            end
            FETCH_REQ: begin
                if (instr_gnt_ip || branch_taken_ip) begin
                    if (!drop_q) inflight_pc_d = fetch_pc_q;
                end
                if (instr_gnt_ip) state_d = FETCH_WAIT;
                if (branch_taken_ip) begin
                    fetch_pc_d = target;
                    drop_d     = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (instr_rvalid_ip) begin
                    state_d = FETCH_REQ;
                    if (drop_q || branch_taken_ip) begin
                        drop_d = 1'b0;
                    end else if (stall_ip) begin
                        hold_load = 1'b1;
                        state_d   = FETCH_HOLD;
                    end else begin
                        deliver    = '{instr: instr_rdata_ip, pc: inflight_pc_q, valid: 1'b1};
                        fetch_pc_d = inflight_pc_q + 32'd4;
                    end
                end else if (branch_taken_ip) begin
                    drop_d = 1'b1;
                end
                if (branch_taken_ip) fetch_pc_d = target;
            end
            FETCH_HOLD: begin
                if (branch_taken_ip) begin
                    fetch_pc_d = target;
                    state_d    = FETCH_REQ;
                end else if (!stall_ip) begin
                    deliver    = '{instr: hold_instr_q, pc: hold_pc_q, valid: 1'b1};
                    fetch_pc_d = hold_pc_q + 32'd4;
                    state_d    = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // FSM state, fetch PC, in-flight PC and drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH_IDLE;
            fetch_pc_q    <= BOOT_ADDR;
            inflight_pc_q <= BOOT_ADDR;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
        end
    end

    // Hold buffer capture for a response that lands during a stall
    always_ff @(posedge clk) begin
        // NOTE: pure data storage is left unreset; it is only read in HOLD, which is always entered through a write.
        if (hold_load) begin
            hold_instr_q <= instr_rdata_ip;
            hold_pc_q    <= inflight_pc_q;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .stall (stall_ip),
        .flush (branch_taken_ip),
        .load  (deliver),
        .q     (if_id_q)
    );

    assign ID_instr_op = if_id_q.instr;
    assign ID_pc_op    = if_id_q.pc;
    assign ID_valid_op = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    // Saturating stall-cycle and redirect counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_op <= 32'h0;
            flush_cnt_op    <= 32'h0;
        end else begin
            if (stall_ip)        stall_cycles_op <= sat_inc(stall_cycles_op);
            if (branch_taken_ip) flush_cnt_op    <= sat_inc(flush_cnt_op);
        end
    end
`endif

endmodule
